// File: rtl/dphy_lane_pkg.sv
// Shared definitions for the D-PHY data-lane HS burst sequencer:
// state encoding, sync byte, LP line-state constants and default timings.
package dphy_lane_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LPX   = 3'd1,
    ST_PREP  = 3'd2,
    ST_ZERO  = 3'd3,
    ST_SYNC  = 3'd4,
    ST_DATA  = 3'd5,
    ST_TRAIL = 3'd6,
    ST_EXIT  = 3'd7
  } lane_state_e;

  localparam logic [7:0] SYNC_BYTE = 8'hB8;

  // LP line levels as {lp_p, lp_n}
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;

  localparam int DEF_T_LPX   = 2;
  localparam int DEF_T_PREP  = 2;
  localparam int DEF_T_ZERO  = 4;
  localparam int DEF_T_TRAIL = 2;
  localparam int DEF_T_EXIT  = 2;

  function automatic int max_of(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/mux.sv
// Width-parameterised 2:1 mux: c = s ? a : b.
module mux #(
  parameter int w = 8
) (
  input  logic [w-1:0] a,
  input  logic [w-1:0] b,
  input  logic         s,
  output logic [w-1:0] c
);

  // One select gate per bit
  for (genvar gi = 0; gi < w; gi++) begin : g_bit
    assign c[gi] = s ? a[gi] : b[gi];
  end

endmodule

// File: rtl/hs_lane_seq.sv
// HS burst sequencer for one D-PHY data lane: LP-11 -> LP-01 -> LP-00 ->
// HS-zero -> sync -> payload -> trail -> LP-11. All line outputs are
// registered from the current state so they move together, one cycle
// behind the state register.
module hs_lane_seq
  import dphy_lane_pkg::*;
#(
  parameter int W       = 8,
  parameter int T_LPX   = DEF_T_LPX,
  parameter int T_PREP  = DEF_T_PREP,
  parameter int T_ZERO  = DEF_T_ZERO,
  parameter int T_TRAIL = DEF_T_TRAIL,
  parameter int T_EXIT  = DEF_T_EXIT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         tx_req,
  input  logic [W-1:0] tx_data,
  input  logic         tx_valid,
  output logic         tx_ready,
  output logic         busy,
  output logic         lp_p,
  output logic         lp_n,
  output logic         hs_en,
  output logic [W-1:0] hs_byte
);

  localparam int T_MAX = max_of(max_of(max_of(T_LPX, T_PREP), max_of(T_ZERO, T_TRAIL)), T_EXIT);
  localparam int CW    = $clog2(T_MAX) + 1;

  localparam logic [W-1:0]  SYNC_WORD = W'(SYNC_BYTE);
  localparam logic [CW-1:0] LD_LPX    = CW'(T_LPX - 1);
  localparam logic [CW-1:0] LD_PREP   = CW'(T_PREP - 1);
  localparam logic [CW-1:0] LD_ZERO   = CW'(T_ZERO - 1);
  localparam logic [CW-1:0] LD_TRAIL  = CW'(T_TRAIL - 1);
  localparam logic [CW-1:0] LD_EXIT   = CW'(T_EXIT - 1);

  lane_state_e   state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic          last_msb_reg;
  logic          lp_p_reg, lp_n_reg, hs_en_reg;
  logic [W-1:0]  hs_byte_reg;

  logic [1:0]    lp_next;
  logic          hs_en_next;
  logic [W-1:0]  pattern;
  logic [W-1:0]  mux_out;
  logic          sel_data;
  logic          cnt_done;

  assign cnt_done = (cnt_reg == '0);
  assign sel_data = (state_reg == ST_DATA);

  // Next-state and timing-counter logic; timed states reload on entry
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      ST_IDLE: begin
        if (tx_req) begin
          state_next = ST_LPX;
          cnt_next   = LD_LPX;
        end
      end
      ST_LPX: begin
        if (cnt_done) begin
          state_next = ST_PREP;
          cnt_next   = LD_PREP;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_PREP: begin
        if (cnt_done) begin
          state_next = ST_ZERO;
          cnt_next   = LD_ZERO;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_ZERO: begin
        if (cnt_done) begin
          state_next = ST_SYNC;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_SYNC: state_next = ST_DATA;
      ST_DATA: begin
        // A single idle cycle from the source closes the burst
        if (!tx_valid) begin
          state_next = ST_TRAIL;
          cnt_next   = LD_TRAIL;
        end
      end
      ST_TRAIL: begin
        if (cnt_done) begin
          state_next = ST_EXIT;
          cnt_next   = LD_EXIT;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      ST_EXIT: begin
        if (cnt_done) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_reg - CW'(1);
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Per-state line decode; trail inverts the MSB of the last byte sent
  always_comb begin
    lp_next    = LP00;
    hs_en_next = 1'b1;
    pattern    = '0;
    case (state_reg)
      ST_LPX:   begin lp_next = LP01; hs_en_next = 1'b0; end
      ST_PREP:  begin lp_next = LP00; hs_en_next = 1'b0; end
      ST_ZERO:  pattern = '0;
      ST_SYNC:  pattern = SYNC_WORD;
      ST_DATA:  pattern = '0;
      ST_TRAIL: pattern = {W{~last_msb_reg}};
      default:  begin lp_next = LP11; hs_en_next = 1'b0; end
    endcase
  end

  mux #(.w(W)) u_mux (
    .a (tx_data),
    .b (pattern),
    .s (sel_data),
    .c (mux_out)
  );

  // State, counter, last-MSB tracker and registered line outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      last_msb_reg <= 1'b0;
      lp_p_reg     <= 1'b1;
      lp_n_reg     <= 1'b1;
      hs_en_reg    <= 1'b0;
      hs_byte_reg  <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      if (state_reg == ST_SYNC) begin
        last_msb_reg <= SYNC_WORD[W-1];
      end else if (sel_data && tx_valid) begin
        last_msb_reg <= tx_data[W-1];
      end
      lp_p_reg    <= lp_next[1];
      lp_n_reg    <= lp_next[0];
      hs_en_reg   <= hs_en_next;
      hs_byte_reg <= mux_out;
    end
  end

  assign tx_ready = (state_reg == ST_DATA);
  assign busy     = (state_reg != ST_IDLE);
  assign lp_p     = lp_p_reg;
  assign lp_n     = lp_n_reg;
  assign hs_en    = hs_en_reg;
  assign hs_byte  = hs_byte_reg;

endmodule

// File: tb/tb_hs_lane_seq.sv
// Directed bench for hs_lane_seq: table-driven bursts with hand-computed
// line/byte expectations, plus hand sequences for reset and held requests.
module tb_hs_lane_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, busy, lp_p, lp_n, hs_en;
  logic [7:0] hs_byte;

  int checks = 0;
  int errors = 0;

  hs_lane_seq #(
    .W(8), .T_LPX(2), .T_PREP(2), .T_ZERO(3), .T_TRAIL(2), .T_EXIT(2)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .tx_req   (tx_req),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .lp_p     (lp_p),
    .lp_n     (lp_n),
    .hs_en    (hs_en),
    .hs_byte  (hs_byte)
  );

  always #5 clk = ~clk;

  // Observed vector: {lp_p, lp_n, hs_en, hs_byte, tx_ready, busy}
  typedef struct {
    logic        req;
    logic        valid;
    logic [7:0]  data;
    logic [12:0] exp;
  } row_t;

  row_t tbl[$];

  function automatic logic [12:0] pk(input logic [1:0] lp, input logic en,
                                     input logic [7:0] hb, input logic rdy,
                                     input logic bsy);
    return {lp, en, hb, rdy, bsy};
  endfunction

  function automatic logic [12:0] obs();
    return {lp_p, lp_n, hs_en, hs_byte, tx_ready, busy};
  endfunction

  task automatic check(input string name, input logic [12:0] act, input logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got lp=%b en=%b byte=%h rdy=%b busy=%b, want lp=%b en=%b byte=%h rdy=%b busy=%b",
               name, act[12:11], act[10], act[9:2], act[1], act[0],
               exp[12:11], exp[10], exp[9:2], exp[1], exp[0]);
    end else begin
      $display("ok   %s: lp=%b en=%b byte=%h rdy=%b busy=%b",
               name, act[12:11], act[10], act[9:2], act[1], act[0]);
    end
  endtask

  task automatic add(input logic req, input logic valid, input logic [7:0] data,
                     input logic [12:0] exp);
    row_t r;
    r.req = req; r.valid = valid; r.data = data; r.exp = exp;
    tbl.push_back(r);
  endtask

  // One full burst starting from IDLE. Each row: inputs before an edge and
  // the outputs expected just after it. The edge that leaves DATA still
  // captures tx_data (mux select is state == DATA), so that slot shows 'junk'.
  task automatic build_burst(input int n, input logic [7:0] b0, input logic [7:0] b1,
                             input logic [7:0] b2, input logic [7:0] junk,
                             input logic [7:0] trail, input logic tail_valid,
                             input logic [7:0] tail_data, input logic toggle);
    logic [7:0] pay [3];
    int k;
    pay[0] = b0; pay[1] = b1; pay[2] = b2;
    k = 1;
    add(1'b1, 1'b0, 8'h00, pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b1));          // IDLE samples req
    for (int i = 0; i < 2; i++) begin
      add(toggle & k[0], 1'b0, 8'h00, pk(2'b01, 1'b0, 8'h00, 1'b0, 1'b1)); k++;
    end
    for (int i = 0; i < 2; i++) begin
      add(toggle & k[0], 1'b0, 8'h00, pk(2'b00, 1'b0, 8'h00, 1'b0, 1'b1)); k++;
    end
    for (int i = 0; i < 3; i++) begin
      add(toggle & k[0], 1'b0, 8'h00, pk(2'b00, 1'b1, 8'h00, 1'b0, 1'b1)); k++;
    end
    add(toggle & k[0], 1'b0, 8'h00, pk(2'b00, 1'b1, 8'hB8, 1'b1, 1'b1)); k++; // sync
    for (int i = 0; i < n; i++) begin
      add(toggle & k[0], 1'b1, pay[i], pk(2'b00, 1'b1, pay[i], 1'b1, 1'b1)); k++;
    end
    add(toggle & k[0], 1'b0, junk, pk(2'b00, 1'b1, junk, 1'b0, 1'b1)); k++;
    for (int i = 0; i < 2; i++) begin
      add(toggle & k[0], tail_valid, tail_data, pk(2'b00, 1'b1, trail, 1'b0, 1'b1)); k++;
    end
    add(toggle & k[0], 1'b0, 8'h00, pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b1)); k++;
    add(toggle & k[0], 1'b0, 8'h00, pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));
    add(1'b0, 1'b0, 8'h00, pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));          // stays IDLE
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      tx_req   = tbl[i].req;
      tx_valid = tbl[i].valid;
      tx_data  = tbl[i].data;
      @(posedge clk);
      #1;
      check($sformatf("%s row%0d", name, i), obs(), tbl[i].exp);
    end
    tbl.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int gap;
    int phase;
    int cyc;
    logic done;

    // Reset held: inputs wiggle, outputs stay at reset values
    for (int i = 0; i < 4; i++) begin
      tx_req   = i[0];
      tx_valid = ~i[0];
      tx_data  = 8'hF0 ^ 8'(i);
      @(posedge clk);
      #1;
      check($sformatf("reset_hold%0d", i), obs(), pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));
    end
    @(negedge clk);
    rst_n = 1'b1;

    // First request is sampled on the first edge after release
    build_burst(3, 8'h11, 8'h22, 8'hA5, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b1);
    run_table("burst3_togglereq");

    build_burst(1, 8'h11, 8'h00, 8'h00, 8'h3C, 8'hFF, 1'b0, 8'h00, 1'b0);
    run_table("burst1");

    build_burst(0, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    run_table("burst0");

    // Valid drops after one byte; later bytes offered in TRAIL are ignored
    build_burst(1, 8'h11, 8'h00, 8'h00, 8'h22, 8'hFF, 1'b1, 8'hA5, 1'b0);
    run_table("valid_drop");

    // Reset pulsed in DATA, between clock edges
    tx_req = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    repeat (9) @(posedge clk);
    #1;
    tx_req = 1'b0; tx_valid = 1'b1; tx_data = 8'h11;
    @(posedge clk);
    #1;
    check("mid_data_byte", obs(), pk(2'b00, 1'b1, 8'h11, 1'b1, 1'b1));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset", obs(), pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));
    tx_data = 8'h22;
    @(posedge clk);
    #1;
    check("reset_held_edge", obs(), pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));
    @(negedge clk);
    rst_n = 1'b1;
    build_burst(3, 8'h11, 8'h22, 8'hA5, 8'h3C, 8'h00, 1'b0, 8'h00, 1'b0);
    run_table("after_reset");

    // tx_req held high: measure the LP-11 gap between two bursts
    tx_req = 1'b1; tx_valid = 1'b0; tx_data = 8'h00;
    gap = 0; phase = 0; cyc = 0; done = 1'b0;
    while (!done && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
      case (phase)
        0: if (hs_en) phase = 1;
        1: if (!hs_en) begin phase = 2; gap = 1; end
        default: begin
          if (lp_p && lp_n && !hs_en) gap++;
          else done = 1'b1;
        end
      endcase
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL held_req_timeout: no second burst seen within %0d cycles", cyc);
    end else if (gap != 3) begin
      errors++;
      $display("FAIL held_req_gap: got %0d LP-11 cycles, want 3", gap);
    end else begin
      $display("ok   held_req_gap: %0d LP-11 cycles", gap);
    end
    check("held_req_second_start", obs(), pk(2'b01, 1'b0, 8'h00, 1'b0, 1'b1));
    tx_req = 1'b0;
    cyc = 0;
    while (busy && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    repeat (3) @(posedge clk);
    #1;
    check("final_idle", obs(), pk(2'b11, 1'b0, 8'h00, 1'b0, 1'b0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hs_lane_seq.md
# hs_lane_seq

HS burst sequencer for one D-PHY data lane. It walks the lane from LP-11 stop state through LP-01, LP-00 and HS-zero, then sends the sync byte, streams payload bytes through a valid/ready handshake, and finishes with HS-trail and LP-11 exit. It drives the lane's pattern/payload `mux` select, so every HS byte (zero, sync, payload, trail) passes through one registered output path. It sits between the lane's byte-stream source and the serializer/LP driver.

## Interface
- `W`, 8: HS byte width. Legal range is W ≥ 8. The sync pattern occupies bits [7:0]; upper bits are 0.
- `T_LPX`, 2: cycles in LP-01 (≥1).
- `T_PREP`, 2: cycles in LP-00 (≥1).
- `T_ZERO`, 4: cycles of HS-zero bytes (≥1).
- `T_TRAIL`, 2: cycles of trail bytes (≥1).
- `T_EXIT`, 2: cycles in LP-11 after HS before accepting a new request (≥1).
- `clk`  in  1  lane byte clock; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tx_req`  in  1  burst request, level-sampled in IDLE only.
- `tx_data`  in  W  payload byte.
- `tx_valid`  in  1  payload byte valid.
- `tx_ready`  out  1  high exactly while state is DATA. Decoded from the state register only; no input-to-output path.
- `busy`  out  1  state ≠ IDLE (decoded from state).
- `lp_p`, `lp_n`  out  1 each  LP line levels (registered).
- `hs_en`  out  1  HS driver enable (registered).
- `hs_byte`  out  W  HS byte to the serializer (registered `mux` output).

## Operation
- States, in order: IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
- IDLE → LPX when `tx_req` = 1.
- LPX, PREP, ZERO, TRAIL and EXIT each last exactly their T_* cycles, counted by one down-counter. The counter is loaded with T−1 on entry to each state. Counter width is $clog2 of the largest T_* plus 1.
- ZERO → SYNC, which lasts 1 cycle → DATA.
- DATA: each cycle with `tx_valid` = 1 transfers `tx_data`.
  - The first DATA cycle with `tx_valid` = 0 ends the burst: DATA → TRAIL.
  - A burst with zero payload bytes is legal.
- EXIT → IDLE.
- `tx_req` is ignored outside IDLE. Deasserting it mid-burst has no effect.
- Line decode per state, as {lp_p, lp_n, hs_en, pattern}:
  - IDLE/EXIT: 1,1,0,0
  - LPX: 0,1,0,0
  - PREP: 0,0,0,0
  - ZERO: 0,0,1,0
  - SYNC: 0,0,1,8'hB8
  - DATA: 0,0,1,payload
  - TRAIL: 0,0,1,trail
- Trail byte = {W{~last_msb}}, where last_msb is bit W−1 of the last byte sent (the sync byte if no payload was sent). last_msb is a flop updated on every SYNC cycle and every DATA transfer.
- `mux` select: `s` = 1 (state DATA) selects `tx_data`; `s` = 0 selects the state pattern. The mux output is captured into `hs_byte`.

## Timing
- All line outputs (`lp_p`, `lp_n`, `hs_en`, `hs_byte`) are registered from the current state. They lag the state register by exactly one cycle, uniformly, so LP/HS transitions never glitch relative to each other.
- A payload byte accepted at edge e appears on `hs_byte` in the cycle after e. Consecutive accepted bytes appear back-to-back with no bubble.
- Minimum request-to-first-payload-byte: T_LPX + T_PREP + T_ZERO + 3 cycles after the edge that samples `tx_req`.
- Reset values: state IDLE, `lp_p` = `lp_n` = 1, `hs_en` = 0, `hs_byte` = 0, `tx_ready` = 0, `busy` = 0, counter = 0, last_msb = 0.
- Reset asserted mid-burst forces all of the above immediately (asynchronously). Any in-flight byte is dropped.
- Reset release: the first request can be sampled on the first clock edge after deassertion.
- `tx_req` held high continuously: a new burst starts T_EXIT cycles after TRAIL ends, with IDLE lasting 1 cycle.

## Structure
- Shared package `dphy_lane_pkg`:
  - state enum
  - `SYNC_BYTE` = 8'hB8
  - line-state constants LP11/LP01/LP00
  - default T_* values
- Sub-module: the existing width-parameterised `mux` (parameter `w`, ports `a`/`b`/`s`/`c`). One instance: `a` = `tx_data`, `b` = state pattern, `s` = (state == DATA).
- Everything else is inline: FSM, counter, last_msb flop, output register.

## Test plan
Defaults for all scenarios: W = 8, T_LPX = 2, T_PREP = 2, T_ZERO = 3, T_TRAIL = 2, T_EXIT = 2.
- Reset: hold `rst_n` = 0 and toggle inputs → lp = 11, `hs_en` = 0, `hs_byte` = 0, `tx_ready` = 0, `busy` = 0.
- Burst of 0x11, 0x22, 0xA5 with `tx_valid` high throughout → lines show:
  - lp 01 ×2, lp 00 ×2
  - `hs_byte` 00 ×3, B8, 11, 22, A5
  - trail 00 ×2 (MSB of A5 = 1)
  - then lp 11 with `hs_en` = 0.
- Single byte 0x11 → trail byte FF ×2. Zero-payload burst → sync B8, then trail 00 ×2.
- `tx_valid` drops after 1 byte of a 3-byte stream → burst ends after that byte. `tx_ready` is low in TRAIL; the remaining bytes are not consumed.
- `rst_n` pulsed low during DATA → outputs return to reset values immediately. The next `tx_req` runs a clean full sequence.
- `tx_req` held high for 2 bursts → gap of exactly T_EXIT + 1 cycles with lp = 11 between them. `tx_req` toggling mid-burst changes nothing.
